text_console: RTL and testbench

Upstream character writer for the 800x600 text display. It accepts an ASCII byte stream over a valid/ready handshake and tracks a cursor on a 100x37 character grid. It issues single-cycle writes into the 4 KiB character memory's write port (address = row*100 + col). It also handles CR/LF/BS/FF, line wrap with line clearing, and a full-screen clear after reset. The cursor position is exported so the display stage can draw the cursor block.

---
 rtl/text_console_pkg.sv | 29 ++
 rtl/text_row_base.sv | 12 +
 rtl/text_console.sv | 173 +++++++++++++++++
 tb/tb_text_console.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and byte classification for the text console writer.
package text_console_pkg;

    localparam int unsigned COLS = 100;
    localparam int unsigned ROWS = 37;
    localparam logic [7:0]  BLANK = 8'h20;

    localparam logic [7:0]  CR = 8'h0D;
    localparam logic [7:0]  LF = 8'h0A;
    localparam logic [7:0]  BS = 8'h08;
    localparam logic [7:0]  FF = 8'h0C;

    localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
    localparam logic [5:0]  ROW_LAST    = 6'(ROWS - 1);
    localparam logic [11:0] LINE_LAST   = 12'(COLS - 1);
    localparam logic [11:0] SCREEN_LAST = 12'(ROWS * COLS - 1);

    typedef enum logic [1:0] {
        CLR_SCREEN = 2'd0,
        IDLE       = 2'd1,
        CLR_LINE   = 2'd2
    } state_e;

    // Bytes that are drawn into the grid rather than interpreted.
    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= 8'h20) && (ch <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_row_base.sv
// Row base address y*100 built from shifts and adds (64y + 32y + 4y).
module text_row_base (
    input  logic [5:0]  i_row,
    output logic [11:0] o_base
);

    logic [11:0] w_row12;

    assign w_row12 = {6'd0, i_row};
    assign o_base  = (w_row12 << 6) + (w_row12 << 5) + (w_row12 << 2);

endmodule

// File: rtl/text_console.sv
// Character writer: accepts bytes, tracks the cursor and writes the character memory,
// including line clears on line advance and a full-screen clear after reset or FF.
module text_console
    import text_console_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  CH_DATA,
    input  logic        CH_VALID,
    output logic        CH_READY,
    output logic [11:0] WR_ADDR,
    output logic [7:0]  WR_DATA,
    output logic        WR_EN,
    output logic [6:0]  CUR_X,
    output logic [5:0]  CUR_Y
);

    state_e      r_state, w_state_next;
    logic [11:0] r_cnt, w_cnt_next;
    logic [6:0]  r_x, w_x_next;
    logic [5:0]  r_y, w_y_next, w_y_adv;
    logic        r_ready, w_ready_next;
    logic        r_wr_en, w_wr_en_next;
    logic [11:0] r_wr_addr, w_wr_addr_next;
    logic [7:0]  r_wr_data, w_wr_data_next;
    logic [11:0] w_base_cur;
    logic        w_accept, w_print, w_wrap;

    // r_ready is only ever high while in IDLE, so it alone qualifies acceptance.
    assign w_accept = CH_VALID && r_ready;
    assign w_print  = is_printable(CH_DATA);
    assign w_wrap   = w_print && (r_x == COL_LAST);
    assign w_y_adv  = (r_y == ROW_LAST) ? 6'd0 : (r_y + 6'd1);

    text_row_base u_row_base (
        .i_row  (r_y),
        .o_base (w_base_cur)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= CLR_SCREEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: clears run to their terminal count, IDLE dispatches on the byte.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLR_SCREEN: begin
                if (r_cnt == SCREEN_LAST) w_state_next = IDLE;
                else                      w_state_next = CLR_SCREEN;
            end
            CLR_LINE: begin
                if (r_cnt == LINE_LAST) w_state_next = IDLE;
                else                    w_state_next = CLR_LINE;
            end
            IDLE: begin
                if (w_accept && (CH_DATA == FF))                  w_state_next = CLR_SCREEN;
                else if (w_accept && ((CH_DATA == LF) || w_wrap)) w_state_next = CLR_LINE;
                else                                              w_state_next = IDLE;
            end
            default: w_state_next = CLR_SCREEN;
        endcase
    end

    // Output/datapath decode: next values of the write port, cursor, counter and ready.
    // A line clear raises ready together with its last write; a screen clear raises it
    // the cycle after, once IDLE has been reached.
    always_comb begin
        w_cnt_next     = 12'd0;
        w_x_next       = r_x;
        w_y_next       = r_y;
        w_ready_next   = 1'b0;
        w_wr_en_next   = 1'b0;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        case (r_state)
            CLR_SCREEN: begin
                w_wr_en_next   = 1'b1;
                w_wr_addr_next = r_cnt;
                w_wr_data_next = BLANK;
                if (r_cnt == SCREEN_LAST) w_cnt_next = 12'd0;
                else                      w_cnt_next = r_cnt + 12'd1;
            end
            CLR_LINE: begin
                w_wr_en_next   = 1'b1;
                w_wr_addr_next = w_base_cur + r_cnt;
                w_wr_data_next = BLANK;
                if (r_cnt == LINE_LAST) begin
                    w_cnt_next   = 12'd0;
                    w_ready_next = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + 12'd1;
                    w_ready_next = 1'b0;
                end
            end
            IDLE: begin
                w_ready_next = 1'b1;
                if (w_accept && w_print) begin
                    w_wr_en_next   = 1'b1;
                    w_wr_addr_next = w_base_cur + {5'd0, r_x};
                    w_wr_data_next = CH_DATA;
                    if (w_wrap) begin
                        w_x_next     = 7'd0;
                        w_y_next     = w_y_adv;
                        w_ready_next = 1'b0;
                    end else begin
                        w_x_next     = r_x + 7'd1;
                    end
                end else if (w_accept) begin
                    case (CH_DATA)
                        CR: w_x_next = 7'd0;
                        LF: begin
                            w_y_next     = w_y_adv;
                            w_ready_next = 1'b0;
                        end
                        BS: begin
                            if (r_x != 7'd0) w_x_next = r_x - 7'd1;
                            else             w_x_next = r_x;
                        end
                        FF: begin
                            // First blank goes out now so the clear spans exactly ROWS*COLS cycles.
                            w_x_next       = 7'd0;
                            w_y_next       = 6'd0;
                            w_ready_next   = 1'b0;
                            w_wr_en_next   = 1'b1;
                            w_wr_addr_next = 12'd0;
                            w_wr_data_next = BLANK;
                            w_cnt_next     = 12'd1;
                        end
                        default: w_x_next = r_x;
                    endcase
                end else begin
                    w_x_next = r_x;
                end
            end
            default: w_cnt_next = 12'd0;
        endcase
    end

    // Registered outputs, cursor and shared clear counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt     <= 12'd0;
            r_x       <= 7'd0;
            r_y       <= 6'd0;
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 12'd0;
            r_wr_data <= 8'd0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_x       <= w_x_next;
            r_y       <= w_y_next;
            r_ready   <= w_ready_next;
            r_wr_en   <= w_wr_en_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
        end
    end

    assign CH_READY = r_ready;
    assign WR_EN    = r_wr_en;
    assign WR_ADDR  = r_wr_addr;
    assign WR_DATA  = r_wr_data;
    assign CUR_X    = r_x;
    assign CUR_Y    = r_y;

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: directed scenarios plus a random byte stream,
// all checked against a grid/queue reference model of the writer.
module tb_text_console;

    localparam int NCOL = 100;
    localparam int NROW = 37;
    localparam logic [7:0] SP = 8'h20;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ch_data;
    logic        ch_valid;
    logic        ch_ready;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;

    int n_checks = 0;
    int n_fail   = 0;
    int mx = 0;
    int my = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    text_console dut (
        .CLK      (clk),
        .RESET    (reset),
        .CH_DATA  (ch_data),
        .CH_VALID (ch_valid),
        .CH_READY (ch_ready),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .WR_EN    (wr_en),
        .CUR_X    (cur_x),
        .CUR_Y    (cur_y)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_row(input int row);
        for (int c = 0; c < NCOL; c++) exp_q.push_back({12'(row * NCOL + c), SP});
    endtask

    task automatic push_screen();
        for (int a = 0; a < NROW * NCOL; a++) exp_q.push_back({12'(a), SP});
    endtask

    task automatic advance_line();
        my = (my + 1) % NROW;
        push_row(my);
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({12'(my * NCOL + mx), b});
            if (mx == NCOL - 1) begin
                mx = 0;
                advance_line();
            end else begin
                mx++;
            end
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h0A) begin
            advance_line();
        end else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end else if (b == 8'h0C) begin
            mx = 0;
            my = 0;
            push_screen();
        end
    endtask

    // Every write the DUT makes must be the next one the model predicted.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            check_eq("write_was_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", wr_addr, mon_e[19:8]);
                check_eq("wr_data", wr_data, mon_e[7:0]);
            end
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic send(input logic [7:0] b);
        int waited = 0;
        ch_data  = b;
        ch_valid = 1'b1;
        while (ch_ready !== 1'b1 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (ch_ready !== 1'b1) begin
            check_eq("ready_timeout", ch_ready, 1);
            ch_valid = 1'b0;
            return;
        end
        model_accept(b);
        @(negedge clk);
        ch_valid = 1'b0;
        check_eq("cur_x", cur_x, mx);
        check_eq("cur_y", cur_y, my);
        if (b >= 8'h20 && b <= 8'h7E) check_eq("print_write_latency", wr_en, 1);
        else if (b != 8'h0A && b != 8'h0C) check_eq("ctrl_no_write", wr_en, 0);
    endtask

    task automatic wait_ready(output int lo, output int wr);
        lo = 0;
        wr = 0;
        while (ch_ready !== 1'b1 && lo < 5000) begin
            if (wr_en === 1'b1) wr++;
            lo++;
            @(negedge clk);
        end
        if (wr_en === 1'b1) wr++;
    endtask

    task automatic do_reset();
        int lo, wr;
        reset    = 1'b1;
        ch_valid = 1'b0;
        @(posedge clk);
        #1 exp_q.delete();
        @(negedge clk);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_ready", ch_ready, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_cur_x", cur_x, 0);
        check_eq("rst_cur_y", cur_y, 0);
        reset = 1'b0;
        mx = 0;
        my = 0;
        push_screen();
        @(negedge clk);
        check_eq("rst_first_write", wr_en, 1);
        wait_ready(lo, wr);
        check_eq("rst_ready_low_cycles", lo, NROW * NCOL);
        check_eq("rst_clear_writes", wr, NROW * NCOL);
        check_eq("rst_cursor_x", cur_x, 0);
        check_eq("rst_cursor_y", cur_y, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, wr, r, found;
        logic [7:0] b;
        logic [7:0] others [6];
        others[0] = 8'h00; others[1] = 8'h09; others[2] = 8'h1B;
        others[3] = 8'h7F; others[4] = 8'h80; others[5] = 8'hFF;

        reset    = 1'b1;
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        do_reset();

        // "AB" back to back from (0,0)
        send(8'h41);
        send(8'h42);
        check_eq("ab_cur_x", cur_x, 2);
        check_eq("ab_no_extra_write", wr_en, 1);

        // FF clear duration
        send(8'h0C);
        wait_ready(lo, wr);
        check_eq("ff_ready_low_cycles", lo, NROW * NCOL);
        check_eq("ff_clear_writes", wr, NROW * NCOL);

        // walk to (5,36), then CR+LF wraps to row 0
        repeat (36) begin
            send(8'h0A);
            wait_ready(lo, wr);
        end
        repeat (5) send(8'h71);
        check_eq("pre_crlf_x", cur_x, 5);
        check_eq("pre_crlf_y", cur_y, 36);
        send(8'h0D);
        send(8'h0A);
        wait_ready(lo, wr);
        check_eq("lf_ready_low_cycles", lo, NCOL);
        check_eq("lf_clear_writes", wr, NCOL);
        check_eq("crlf_cur_x", cur_x, 0);
        check_eq("crlf_cur_y", cur_y, 0);

        // 100 'x' from (0,3): a full row, then wrap with line clear
        repeat (3) begin
            send(8'h0A);
            wait_ready(lo, wr);
        end
        repeat (NCOL) send(8'h78);
        wait_ready(lo, wr);
        check_eq("wrap_ready_low_cycles", lo, NCOL);
        check_eq("wrap_consecutive_writes", wr, NCOL + 1);
        check_eq("wrap_cur_x", cur_x, 0);
        check_eq("wrap_cur_y", cur_y, 4);

        // backspace at column 0 and mid-row
        repeat (3) begin
            send(8'h0A);
            wait_ready(lo, wr);
        end
        send(8'h08);
        check_eq("bs0_cur_x", cur_x, 0);
        check_eq("bs0_cur_y", cur_y, 7);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        send(8'h08);
        send(8'h5A);
        check_eq("bs_z_addr", wr_addr, 702);
        check_eq("bs_z_data", wr_data, 8'h5A);

        // random stream with idle gaps
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32'h20, 32'h7E));
            else if (r < 78) b = 8'h0D;
            else if (r < 86) b = 8'h0A;
            else if (r < 92) b = 8'h08;
            else if (r < 93) b = 8'h0C;
            else             b = others[$urandom_range(0, 5)];
            send(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // reset in the middle of an FF clear
        send(8'h0C);
        found = 0;
        for (int k = 0; k < 5000 && found == 0; k++) begin
            if (wr_en === 1'b1 && wr_addr == 12'd1500) found = 1;
            else @(negedge clk);
        end
        check_eq("midclear_reached_1500", found, 1);
        do_reset();

        repeat (3) @(negedge clk);
        check_eq("expected_writes_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
